// File: rtl/pac_motion.sv
// pac_motion: owns Pac-Man's position, heading, bean grid, score and the
// sticky game-over flag. On each move tick it probes the wall map at the
// four corners of the 32x32 sprite at the candidate position (requested
// direction first, current heading as fallback), commits a legal step and
// then eats the bean under the sprite centre.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   move_tick         one-cycle move-rate strobe (ignored unless idle)
//   dir_req[3:0]      key levels {up,down,left,right}, up has priority
//   GhostX, GhostY    ghost top-left position
//   wall_hit          combinational wall-map answer for (wall_x, wall_y)
//   wall_x, wall_y    wall probe coordinate (0 when not probing)
//   PacX, PacY        sprite top-left position
//   state             heading: 00 down, 01 up, 10 right, 11 left
//   beanmap           remaining beans, bit index = row*40+col
//   score             beans eaten, saturates at 1200
//   over              sticky game over
module pac_motion #(
  parameter logic [9:0]    START_X   = 10'd16,
  parameter logic [8:0]    START_Y   = 9'd16,
  parameter int            STEP      = 2,
  parameter logic [1199:0] BEAN_INIT = {1200{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          move_tick,
  input  logic [3:0]    dir_req,
  input  logic [9:0]    GhostX,
  input  logic [8:0]    GhostY,
  input  logic          wall_hit,
  output logic [9:0]    wall_x,
  output logic [8:0]    wall_y,
  output logic [9:0]    PacX,
  output logic [8:0]    PacY,
  output logic [1:0]    state,
  output logic [1199:0] beanmap,
  output logic [10:0]   score,
  output logic          over
);

  typedef enum logic [3:0] {
    IDLE, PROBE_A0, PROBE_A1, PROBE_A2, PROBE_A3,
    PROBE_B0, PROBE_B1, PROBE_B2, PROBE_B3, COMMIT, EAT, HALT
  } fsm_t;

  localparam logic signed [11:0] STEP_S = 12'(STEP);

  fsm_t              fsm_state, fsm_next;
  logic [1:0]        cand_dir, alt_dir, req_dir;
  logic              hit_acc;
  logic signed [11:0] cand_x, cand_y;
  logic              out_of_range, probing, any_hit;
  logic [9:0]        off_x;
  logic [8:0]        off_y;
  logic [6:0]        eat_col;
  logic [5:0]        eat_row;
  logic [10:0]       eat_idx;
  logic signed [10:0] dx, dy;
  logic              overlap, over_next;

  // Requested heading with up > down > left > right; no key keeps heading.
  always_comb begin
    req_dir = state;
    if      (dir_req[3]) req_dir = 2'b01;
    else if (dir_req[2]) req_dir = 2'b00;
    else if (dir_req[1]) req_dir = 2'b11;
    else if (dir_req[0]) req_dir = 2'b10;
  end

  // Candidate position in wide signed form so the range check sees
  // negative and oversized values before truncation.
  always_comb begin
    cand_x = {2'b00, PacX};
    cand_y = {3'b000, PacY};
    case (cand_dir)
      2'b00:   cand_y = cand_y + STEP_S;
      2'b01:   cand_y = cand_y - STEP_S;
      2'b10:   cand_x = cand_x + STEP_S;
      default: cand_x = cand_x - STEP_S;
    endcase
    out_of_range = (cand_x < 0) || (cand_x > 12'sd608) ||
                   (cand_y < 0) || (cand_y > 12'sd448);
  end

  // Corner selection: the probe index picks which of the four sprite
  // corners is presented to the wall map this cycle.
  always_comb begin
    off_x   = 10'd0;
    off_y   = 9'd0;
    probing = 1'b1;
    case (fsm_state)
      PROBE_A0, PROBE_B0: ;
      PROBE_A1, PROBE_B1: off_x = 10'd31;
      PROBE_A2, PROBE_B2: off_y = 9'd31;
      PROBE_A3, PROBE_B3: begin
        off_x = 10'd31;
        off_y = 9'd31;
      end
      default: probing = 1'b0;
    endcase
    wall_x = 10'd0;
    wall_y = 9'd0;
    if (probing && !out_of_range) begin
      wall_x = cand_x[9:0] + off_x;
      wall_y = cand_y[8:0] + off_y;
    end
    any_hit = hit_acc | wall_hit;
  end

  // Bean under the sprite centre: (P+16)>>4 is just the tile index plus one.
  always_comb begin
    eat_col = {1'b0, PacX[9:4]} + 7'd1;
    eat_row = {1'b0, PacY[8:4]} + 6'd1;
    eat_idx = 11'(eat_row) * 11'd40 + 11'(eat_col);
  end

  // Bounding-box overlap with the ghost and the sticky game-over term.
  always_comb begin
    dx        = $signed({1'b0, PacX}) - $signed({1'b0, GhostX});
    dy        = $signed({2'b00, PacY}) - $signed({2'b00, GhostY});
    overlap   = (dx > -11'sd32) && (dx < 11'sd32) &&
                (dy > -11'sd32) && (dy < 11'sd32);
    over_next = over | (beanmap == '0) | overlap;
  end

  // Next-state logic. A blocked or out-of-range primary move falls back to
  // the old heading only when that heading is actually different.
  always_comb begin
    fsm_next = fsm_state;
    if (over) begin
      fsm_next = HALT;
    end else begin
      case (fsm_state)
        IDLE:     if (move_tick) fsm_next = PROBE_A0;
        PROBE_A0: begin
          if (!out_of_range)           fsm_next = PROBE_A1;
          else if (alt_dir != cand_dir) fsm_next = PROBE_B0;
          else                          fsm_next = IDLE;
        end
        PROBE_A1: fsm_next = PROBE_A2;
        PROBE_A2: fsm_next = PROBE_A3;
        PROBE_A3: begin
          if (!any_hit)                 fsm_next = COMMIT;
          else if (alt_dir != cand_dir) fsm_next = PROBE_B0;
          else                          fsm_next = IDLE;
        end
        PROBE_B0: fsm_next = out_of_range ? IDLE : PROBE_B1;
        PROBE_B1: fsm_next = PROBE_B2;
        PROBE_B2: fsm_next = PROBE_B3;
        PROBE_B3: fsm_next = any_hit ? IDLE : COMMIT;
        COMMIT:   fsm_next = EAT;
        EAT:      fsm_next = IDLE;
        default:  fsm_next = HALT;
      endcase
    end
  end

  // Game state registers. Nothing but the FSM moves once over is set, so
  // an in-flight move never commits after a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state <= IDLE;
      PacX      <= START_X;
      PacY      <= START_Y;
      state     <= 2'b10;
      beanmap   <= BEAN_INIT;
      score     <= 11'd0;
      over      <= 1'b0;
      cand_dir  <= 2'b10;
      alt_dir   <= 2'b10;
      hit_acc   <= 1'b0;
    end else begin
      fsm_state <= fsm_next;
      over      <= over_next;
      if (!over) begin
        case (fsm_state)
          IDLE: if (move_tick) begin
            cand_dir <= req_dir;
            alt_dir  <= state;
          end
          PROBE_A0, PROBE_B0: hit_acc <= wall_hit;
          PROBE_A1, PROBE_A2, PROBE_B1, PROBE_B2: hit_acc <= any_hit;
          COMMIT: begin
            PacX  <= cand_x[9:0];
            PacY  <= cand_y[8:0];
            state <= cand_dir;
          end
          EAT: if (eat_idx < 11'd1200 && beanmap[eat_idx]) begin
            beanmap[eat_idx] <= 1'b0;
            if (score != 11'd1200) score <= score + 11'd1;
          end
          default: ;
        endcase
        // The fallback path reuses the candidate logic with the old heading.
        if ((fsm_state == PROBE_A0 || fsm_state == PROBE_A3) &&
            fsm_next == PROBE_B0)
          cand_dir <= alt_dir;
      end
    end
  end

endmodule

// File: tb/tb_pac_motion.sv
// Directed testbench for pac_motion: a default instance (start 16,16, full
// bean map) driven against a small behavioural wall map, and a second
// instance (start 0,0, single bean at index 41) for the eat/game-over path.
module tb_pac_motion;

  localparam logic [1199:0] BEAN41 = {1158'b0, 1'b1, 41'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          move_tick, moveTick2;
  logic [3:0]    dir_req;
  logic [9:0]    ghost_x;
  logic [8:0]    ghost_y;
  logic          wall_hit;
  logic [9:0]    wall_x, pac_x, wallX2, pacX2;
  logic [8:0]    wall_y, pac_y, wallY2, pacY2;
  logic [1:0]    state, state2;
  logic [1199:0] beanmap, beanmap2;
  logic [10:0]   score, score2;
  logic          over, over2;
  int            wallMode;
  int            checkCount = 0;
  int            passCount  = 0;

  pac_motion dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .dir_req(dir_req),
    .GhostX(ghost_x), .GhostY(ghost_y), .wall_hit(wall_hit),
    .wall_x(wall_x), .wall_y(wall_y), .PacX(pac_x), .PacY(pac_y),
    .state(state), .beanmap(beanmap), .score(score), .over(over)
  );

  pac_motion #(.START_X(10'd0), .START_Y(9'd0), .BEAN_INIT(BEAN41)) dut2 (
    .clk(clk), .rst(rst), .move_tick(moveTick2), .dir_req(4'b0001),
    .GhostX(10'd500), .GhostY(9'd400), .wall_hit(1'b0),
    .wall_x(wallX2), .wall_y(wallY2), .PacX(pacX2), .PacY(pacY2),
    .state(state2), .beanmap(beanmap2), .score(score2), .over(over2)
  );

  always #5 clk = ~clk;

  // Wall map model: 0 open, 1 wall at x>=50, 2 wall above row y=16.
  always_comb begin
    wall_hit = 1'b0;
    if (wallMode == 1) wall_hit = (wall_x >= 10'd50);
    else if (wallMode == 2) wall_hit = (wall_y < 9'd16);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulses move_tick for one cycle; returns just after the sampling edge.
  task automatic applyStimulus(input logic [3:0] dir);
    dir_req = dir;
    @(negedge clk) move_tick = 1'b1;
    @(negedge clk) move_tick = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; move_tick = 1'b0; moveTick2 = 1'b0; dir_req = 4'b0;
    ghost_x = 10'd500; ghost_y = 9'd400; wallMode = 0;
    step(3);
    checkOutput("reset PacX", 32'(pac_x), 32'd16);
    checkOutput("reset PacY", 32'(pac_y), 32'd16);
    checkOutput("reset state", 32'(state), 32'd2);
    checkOutput("reset score", 32'(score), 32'd0);
    checkOutput("reset over", 32'(over), 32'd0);
    checkOutput("reset wall_x", 32'(wall_x), 32'd0);
    checkOutput("reset wall_y", 32'(wall_y), 32'd0);
    checkOutput("reset beanmap full", 32'(&beanmap), 32'd1);
    checkOutput("reset dut2 beanmap", 32'(beanmap2 == BEAN41), 32'd1);
    rst = 1'b0;
    step(1);

    // Single-bean instance: move right to (2,0), centre tile idx 41.
    @(negedge clk) moveTick2 = 1'b1;
    @(negedge clk) moveTick2 = 1'b0;
    step(4);
    checkOutput("eat PacX before commit", 32'(pacX2), 32'd0);
    step(1);
    checkOutput("eat PacX at 5 cycles", 32'(pacX2), 32'd2);
    step(1);
    checkOutput("eat score", 32'(score2), 32'd1);
    checkOutput("eat bit41 cleared", 32'(beanmap2[41]), 32'd0);
    checkOutput("eat over not yet", 32'(over2), 32'd0);
    step(1);
    checkOutput("eat over on empty map", 32'(over2), 32'd1);
    @(negedge clk) moveTick2 = 1'b1;
    @(negedge clk) moveTick2 = 1'b0;
    step(12);
    checkOutput("halt no motion dut2", 32'(pacX2), 32'd2);

    // Open corridor to the right, probe corners and 5-cycle latency.
    applyStimulus(4'b0001);
    checkOutput("probe A0 wall_x", 32'(wall_x), 32'd18);
    checkOutput("probe A0 wall_y", 32'(wall_y), 32'd16);
    step(1);
    checkOutput("probe A1 wall_x", 32'(wall_x), 32'd49);
    step(3);
    checkOutput("corridor PacX at 4", 32'(pac_x), 32'd16);
    step(1);
    checkOutput("corridor PacX at 5", 32'(pac_x), 32'd18);
    step(3);
    for (int i = 1; i <= 2; i++) begin
      applyStimulus(4'b0001);
      step(5);
      checkOutput("corridor PacX", 32'(pac_x), 32'(18 + 2 * i));
      step(3);
    end
    checkOutput("corridor state", 32'(state), 32'd2);
    checkOutput("corridor score", 32'(score), 32'd1);
    checkOutput("corridor bean82", 32'(beanmap[82]), 32'd0);

    // Wall at x>=50 stops the sprite at X=18.
    doReset();
    wallMode = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001);
      step(12);
    end
    checkOutput("wall PacX", 32'(pac_x), 32'd18);
    checkOutput("wall state", 32'(state), 32'd2);

    // Up blocked, fallback right through the B path in 9 cycles.
    doReset();
    wallMode = 2;
    applyStimulus(4'b1000);
    step(8);
    checkOutput("fallback PacX at 8", 32'(pac_x), 32'd16);
    step(1);
    checkOutput("fallback PacX at 9", 32'(pac_x), 32'd18);
    checkOutput("fallback PacY", 32'(pac_y), 32'd16);
    checkOutput("fallback state", 32'(state), 32'd2);
    step(4);
    wallMode = 0;
    applyStimulus(4'b0100);
    step(12);
    checkOutput("turn down PacY", 32'(pac_y), 32'd18);
    checkOutput("turn down state", 32'(state), 32'd0);

    // Top edge: eight steps reach Y=0, the ninth would go negative.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b1000);
      step(12);
    end
    checkOutput("top edge PacY", 32'(pac_y), 32'd0);
    checkOutput("top edge state", 32'(state), 32'd1);
    checkOutput("top edge score", 32'(score), 32'd1);

    // Tick while busy is dropped.
    doReset();
    applyStimulus(4'b0001);
    step(1);
    applyStimulus(4'b0001);
    step(14);
    checkOutput("busy single step", 32'(pac_x), 32'd18);

    // Reset in the middle of probing.
    doReset();
    applyStimulus(4'b0001);
    step(1);
    rst = 1'b1;
    #1;
    checkOutput("midprobe wall_x", 32'(wall_x), 32'd0);
    checkOutput("midprobe PacX", 32'(pac_x), 32'd16);
    step(2);
    rst = 1'b0;
    step(12);
    checkOutput("midprobe no move", 32'(pac_x), 32'd16);

    // Ghost overlap: 32 apart is clear, 31 apart ends the game.
    ghost_x = 10'd48; ghost_y = 9'd16;
    step(2);
    checkOutput("ghost dx=32 clear", 32'(over), 32'd0);
    ghost_x = 10'd47;
    step(1);
    checkOutput("ghost dx=31 over", 32'(over), 32'd1);
    applyStimulus(4'b0001);
    step(12);
    checkOutput("halt no motion", 32'(pac_x), 32'd16);
    ghost_x = 10'd500; ghost_y = 9'd400;
    rst = 1'b1;
    #1;
    checkOutput("rst clears over", 32'(over), 32'd0);
    checkOutput("rst score", 32'(score), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    checkOutput("over stays clear", 32'(over), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
